// File: rtl/spi_flash_read_arbiter.sv
// Two-requester READ (0x03) engine for the serial configuration flash.
// SPI mode 0 master with a clk-divided SCK and a back-pressured byte output.
module spi_flash_read_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int CSH_CYC = 4,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [23:0]      req_addr0,
  input  logic [23:0]      req_addr1,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  output logic [1:0]       req_ack,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_owner,
  output logic             rd_last,
  output logic             busy,
  output logic             spi_cs_n,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = $clog2(CSH_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSH_CYC);

  typedef enum logic [2:0] {IDLE, CMD, DATA, HOLD, GAP} state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      shifter;
  logic [7:0]       rx;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             grant_sel;
  logic [23:0]      sel_addr;
  logic [LEN_W-1:0] sel_len;
  logic [31:0]      cmd_word;
  logic             tick;

  // Round-robin: on contention the requester not served last wins.
  always_comb begin
    grant_sel = 1'b0;
    if (req_valid == 2'b11) grant_sel = ~last_grant;
    else if (req_valid[1])  grant_sel = 1'b1;
  end

  assign sel_addr = grant_sel ? req_addr1 : req_addr0;
  assign sel_len  = grant_sel ? req_len1  : req_len0;
  assign cmd_word = {8'h03, sel_addr};
  assign tick     = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      req_ack    <= 2'b00;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_owner   <= 1'b0;
      rd_data    <= 8'h00;
      busy       <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      last_grant <= 1'b1;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      req_ack <= 2'b00;
      case (state)
        IDLE: begin
          if (req_valid != 2'b00) begin
            req_ack    <= grant_sel ? 2'b10 : 2'b01;
            owner      <= grant_sel;
            last_grant <= grant_sel;
            busy       <= 1'b1;
            remaining  <= sel_len;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            spi_sck    <= 1'b0;
            if (sel_len != '0) begin
              shifter  <= cmd_word;
              spi_mosi <= cmd_word[31];
              spi_cs_n <= 1'b0;
              state    <= CMD;
            end else begin
              state    <= GAP;
            end
          end
        end

        // Command/address: mosi advances on each falling SCK edge.
        CMD: begin
          if (tick) begin
            div_cnt <= '0;
            spi_sck <= ~spi_sck;
            if (spi_sck) begin
              shifter  <= {shifter[30:0], 1'b0};
              spi_mosi <= shifter[30];
              if (bit_cnt == 6'd31) begin
                bit_cnt <= '0;
                state   <= DATA;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        // Sample on rising edges; the byte is presented on the 8th falling edge.
        DATA: begin
          if (tick) begin
            div_cnt <= '0;
            spi_sck <= ~spi_sck;
            if (!spi_sck) begin
              rx      <= {rx[6:0], spi_miso};
              bit_cnt <= bit_cnt + 6'd1;
            end else if (bit_cnt == 6'd8) begin
              rd_data  <= rx;
              rd_valid <= 1'b1;
              rd_last  <= (remaining == LEN_W'(1));
              rd_owner <= owner;
              bit_cnt  <= '0;
              state    <= HOLD;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        HOLD: begin
          if (rd_ready) begin
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            remaining <= remaining - LEN_W'(1);
            div_cnt   <= '0;
            if (remaining == LEN_W'(1)) begin
              spi_cs_n <= 1'b1;
              gap_cnt  <= '0;
              state    <= GAP;
            end else begin
              state    <= DATA;
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_read_arbiter.sv
// Directed bench: two arbiter instances (CLK_DIV=2 and CLK_DIV=1), each with a
// behavioural READ-command flash and a handshake/chip-select monitor.
module tb_spi_flash_read_arbiter;
  localparam int CSH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int DIV = (k == 0) ? 2 : 1;
    logic [1:0]  req_valid, req_ack;
    logic [23:0] req_addr0, req_addr1;
    logic [15:0] req_len0, req_len1;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_ready, rd_owner, rd_last, busy;
    logic        cs_n, sck, mosi;
    logic        miso = 1'b0;

    spi_flash_read_arbiter #(.CLK_DIV(DIV), .CSH_CYC(CSH), .LEN_W(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_len0(req_len0), .req_len1(req_len1), .req_ack(req_ack),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_owner(rd_owner), .rd_last(rd_last), .busy(busy),
      .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso)
    );

    // Flash: 32 command bits captured on SCK rise, data bits launched on SCK fall.
    logic [7:0]  stream [16];
    logic [31:0] cmd_sr = '0;
    logic [31:0] last_cmd = '0;
    logic        sck_q = 1'b0;
    int          rise_cnt = 0;
    int          out_idx = 0;
    int          first_rise = 0;
    int          second_rise = 0;

    always @(negedge clk) begin
      sck_q <= sck;
      if (cs_n !== 1'b0) begin
        rise_cnt <= 0;
        out_idx  <= 0;
        miso     <= 1'b0;
      end else begin
        if (sck && !sck_q) begin
          rise_cnt <= rise_cnt + 1;
          cmd_sr   <= {cmd_sr[30:0], mosi};
          if (rise_cnt == 0)  first_rise  <= cyc;
          if (rise_cnt == 1)  second_rise <= cyc;
          if (rise_cnt == 31) last_cmd    <= {cmd_sr[30:0], mosi};
        end
        if (!sck && sck_q && rise_cnt >= 32) begin
          miso    <= stream[out_idx[6:3]][3'd7 - out_idx[2:0]];
          out_idx <= out_idx + 1;
        end
      end
    end

    logic [7:0] lg_byte [64];
    logic       lg_owner [64];
    logic       lg_last [64];
    int         lg_cyc [64];
    int         n_rx = 0;
    int         busy_cyc = 0;
    int         cs_falls = 0;
    int         cs_fall_cyc = 0;
    int         cs_rise_cyc = 0;
    int         last_gap = 0;
    int         ack_busy_err = 0;
    logic       cs_q = 1'b1;
    logic       busy_q = 1'b0;

    always @(posedge clk) begin
      cs_q   <= cs_n;
      busy_q <= busy;
      if (rd_valid && rd_ready) begin
        lg_byte[n_rx[5:0]]  <= rd_data;
        lg_owner[n_rx[5:0]] <= rd_owner;
        lg_last[n_rx[5:0]]  <= rd_last;
        lg_cyc[n_rx[5:0]]   <= cyc;
        n_rx <= n_rx + 1;
      end
      if (busy) busy_cyc <= busy_cyc + 1;
      if (req_ack != 2'b00 && busy_q) ack_busy_err <= ack_busy_err + 1;
      if (cs_q && !cs_n) begin
        cs_falls    <= cs_falls + 1;
        cs_fall_cyc <= cyc;
        last_gap    <= cyc - cs_rise_cyc;
      end
      if (!cs_q && cs_n) cs_rise_cyc <= cyc;
    end
  end

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (g[0].req_ack != 2'b00) begin
        idx = g[0].req_ack[1] ? 1 : 0;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!g[0].busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic issue(input int r, input logic [23:0] a, input logic [15:0] n, output int idx);
    if (r == 0) begin
      g[0].req_addr0 = a;
      g[0].req_len0  = n;
    end else begin
      g[0].req_addr1 = a;
      g[0].req_len1  = n;
    end
    g[0].req_valid[r] = 1'b1;
    wait_ack(idx);
    g[0].req_valid[r] = 1'b0;
  endtask

  initial begin
    int idx, ok, b, stall_bad, b0, c0;
    logic [7:0] held;

    g[0].req_valid = 2'b00; g[0].req_addr0 = '0; g[0].req_addr1 = '0;
    g[0].req_len0 = '0; g[0].req_len1 = '0; g[0].rd_ready = 1'b1;
    g[1].req_valid = 2'b00; g[1].req_addr0 = '0; g[1].req_addr1 = '0;
    g[1].req_len0 = '0; g[1].req_len1 = '0; g[1].rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      g[0].stream[i] = 8'h00;
      g[1].stream[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    check("rst_ctl", {30'd0, g[0].req_ack}, 32'd0);
    check("rst_rd", {g[0].rd_valid, g[0].rd_last, g[0].rd_owner, g[0].rd_data}, 32'd0);
    check("rst_spi", {g[0].busy, g[0].cs_n, g[0].sck, g[0].mosi}, 32'b0100);
    reset = 1'b1;
    @(negedge clk);

    // Contention from reset: req0 first, then req1, then req0 again.
    g[0].stream[0] = 8'h5A;
    b = g[0].n_rx;
    g[0].req_addr0 = 24'h000100; g[0].req_len0 = 16'd1;
    g[0].req_addr1 = 24'h000200; g[0].req_len1 = 16'd1;
    g[0].req_valid = 2'b11;
    wait_ack(idx);
    check("rr_first", idx, 0);
    g[0].req_valid[0] = 1'b0;
    wait_ack(idx);
    check("rr_second", idx, 1);
    check("rr_cmd1", g[0].last_cmd, 32'h03000100);
    g[0].req_valid[1] = 1'b0;
    wait_idle(ok);
    check("rr_done1", ok, 1);
    check("rr_cmd2", g[0].last_cmd, 32'h03000200);
    g[0].req_valid = 2'b11;
    wait_ack(idx);
    check("rr_third", idx, 0);
    g[0].req_valid[0] = 1'b0;
    wait_ack(idx);
    check("rr_fourth", idx, 1);
    g[0].req_valid[1] = 1'b0;
    wait_idle(ok);
    check("rr_done2", ok, 1);
    check("rr_gap", (g[0].last_gap >= CSH), 1);
    check("rr_count", g[0].n_rx - b, 4);
    check("rr_owner", {g[0].lg_owner[b], g[0].lg_owner[b+1], g[0].lg_owner[b+2], g[0].lg_owner[b+3]}, 4'b0101);
    check("rr_data", {g[0].lg_byte[b], g[0].lg_byte[b+3]}, 16'h5A5A);

    // Basic two-byte read.
    g[0].stream[0] = 8'hA5; g[0].stream[1] = 8'h3C;
    b = g[0].n_rx;
    issue(0, 24'h012345, 16'd2, idx);
    check("t1_ack", idx, 0);
    wait_idle(ok);
    check("t1_done", ok, 1);
    check("t1_cmd", g[0].last_cmd, 32'h03012345);
    check("t1_count", g[0].n_rx - b, 2);
    check("t1_data", {g[0].lg_byte[b], g[0].lg_byte[b+1]}, 16'hA53C);
    check("t1_last", {g[0].lg_last[b], g[0].lg_last[b+1]}, 2'b01);
    check("t1_owner", {g[0].lg_owner[b], g[0].lg_owner[b+1]}, 2'b00);
    check("t1_first_sck", g[0].first_rise - g[0].cs_fall_cyc, 2);
    check("t1_sck_period", g[0].second_rise - g[0].first_rise, 4);
    check("t1_spacing", g[0].lg_cyc[b+1] - g[0].lg_cyc[b], 33);
    check("t1_cs_idle", g[0].cs_n, 1'b1);

    // Consumer stall on the first byte of three.
    g[0].stream[0] = 8'h11; g[0].stream[1] = 8'h22; g[0].stream[2] = 8'h33;
    g[0].rd_ready = 1'b0;
    b = g[0].n_rx;
    issue(0, 24'h000010, 16'd3, idx);
    check("t3_ack", idx, 0);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (g[0].rd_valid) begin
        ok = 1;
        break;
      end
    end
    check("t3_valid", ok, 1);
    held = g[0].rd_data;
    stall_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (g[0].sck !== 1'b0 || g[0].cs_n !== 1'b0 || g[0].rd_valid !== 1'b1 || g[0].rd_data !== held)
        stall_bad++;
    end
    check("t3_stall", stall_bad, 0);
    check("t3_held", held, 8'h11);
    g[0].rd_ready = 1'b1;
    wait_idle(ok);
    check("t3_done", ok, 1);
    check("t3_count", g[0].n_rx - b, 3);
    check("t3_data", {g[0].lg_byte[b], g[0].lg_byte[b+1], g[0].lg_byte[b+2]}, 24'h112233);
    check("t3_last", {g[0].lg_last[b], g[0].lg_last[b+1], g[0].lg_last[b+2]}, 3'b001);

    // Zero-length request from requester 1.
    b = g[0].n_rx; b0 = g[0].busy_cyc; c0 = g[0].cs_falls;
    issue(1, 24'h000400, 16'd0, idx);
    check("t4_ack", idx, 1);
    wait_idle(ok);
    check("t4_done", ok, 1);
    check("t4_busy", g[0].busy_cyc - b0, CSH + 1);
    check("t4_no_cs", g[0].cs_falls - c0, 0);
    check("t4_no_rd", g[0].n_rx - b, 0);

    // Reset in the middle of the command phase, then a clean read.
    issue(0, 24'hABCDEF, 16'd1, idx);
    check("t5_ack", idx, 0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (g[0].rise_cnt >= 12) break;
    end
    check("t5_mid_cmd", g[0].cs_n, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst", {g[0].cs_n, g[0].sck, g[0].rd_valid, g[0].busy}, 4'b1000);
    reset = 1'b1;
    @(negedge clk);
    g[0].stream[0] = 8'h77;
    b = g[0].n_rx;
    issue(0, 24'h000020, 16'd1, idx);
    check("t5_ack2", idx, 0);
    wait_idle(ok);
    check("t5_done", ok, 1);
    check("t5_cmd", g[0].last_cmd, 32'h03000020);
    check("t5_data", {g[0].n_rx - b, 8'h00, g[0].lg_byte[b], 7'd0, g[0].lg_last[b]}, {32'd1, 8'h00, 8'h77, 8'h01});

    // CLK_DIV=1 instance, four bytes with rd_ready high.
    g[1].stream[0] = 8'hDE; g[1].stream[1] = 8'hAD; g[1].stream[2] = 8'hBE; g[1].stream[3] = 8'hEF;
    b = g[1].n_rx;
    g[1].req_addr0 = 24'h00FF00; g[1].req_len0 = 16'd4; g[1].req_valid = 2'b01;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (g[1].req_ack[0]) begin
        ok = 1;
        break;
      end
    end
    g[1].req_valid = 2'b00;
    check("t6_ack", ok, 1);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!g[1].busy) begin
        ok = 1;
        break;
      end
    end
    check("t6_done", ok, 1);
    check("t6_cmd", g[1].last_cmd, 32'h0300FF00);
    check("t6_first_sck", g[1].first_rise - g[1].cs_fall_cyc, 1);
    check("t6_sck_period", g[1].second_rise - g[1].first_rise, 2);
    check("t6_count", g[1].n_rx - b, 4);
    check("t6_data", {g[1].lg_byte[b], g[1].lg_byte[b+1], g[1].lg_byte[b+2], g[1].lg_byte[b+3]}, 32'hDEADBEEF);
    check("t6_last", {g[1].lg_last[b], g[1].lg_last[b+1], g[1].lg_last[b+2], g[1].lg_last[b+3]}, 4'b0001);
    for (int i = 0; i < 3; i++)
      check("t6_spacing", g[1].lg_cyc[b+i+1] - g[1].lg_cyc[b+i], 17);

    check("ack_while_busy", g[0].ack_busy_err + g[1].ack_busy_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_flash_read_arbiter.md
# spi_flash_read_arbiter

Sequences read transactions on the board's serial configuration flash and shares it between two requesters, e.g. the ROM image loader and the disk image loader. For each accepted request it issues the flash READ command (0x03) with a 24-bit address, then streams the requested number of bytes out over a valid/ready byte port tagged with the owning requester. It drives the SPI pins directly in mode 0 with a programmable SCK divider. It replaces free-running one-shot readers with a shared, back-pressured engine.

## Interface
- CLK_DIV, 2, clk cycles per SCK half-period (≥1)
- CSH_CYC, 4, minimum clk cycles cs_n stays high between transactions (≥1)
- LEN_W, 16, width of byte-count fields
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-low (reset==0 resets)
- req_valid  in  2  per-requester request pending; held until ack
- req_addr0, req_addr1  in  24  start byte address
- req_len0, req_len1  in  LEN_W  byte count; 0 is legal
- req_ack  out  2  one-cycle pulse: request accepted, fields may change next cycle
- rd_data  out  8  received byte
- rd_valid  out  1  rd_data valid; held until rd_ready
- rd_ready  in  1  consumer accepts byte when rd_valid&&rd_ready
- rd_owner  out  1  requester index of current byte
- rd_last  out  1  final byte of transaction (qualified by rd_valid)
- busy  out  1  high from grant until CSH gap completes
- spi_cs_n  out  1  flash chip select, active low
- spi_sck  out  1  serial clock, idle low
- spi_mosi  out  1  serial data to flash
- spi_miso  in  1  serial data from flash

## Operation
- Reset values: req_ack=0, rd_valid=0, rd_last=0, rd_owner=0, rd_data=0, busy=0, spi_cs_n=1, spi_sck=0, spi_mosi=0, last_grant=1, state=IDLE.
- States: IDLE, CMD, DATA, HOLD, GAP.
- IDLE: if any req_valid, grant round-robin: both valid → requester ≠ last_grant; else the single one. Same cycle: pulse req_ack[g], latch addr/len/owner, update last_grant, busy=1. len≠0 → CMD with cs_n=0, mosi=bit31 of {8'h03, addr}. len=0 → GAP, cs_n never asserted, no byte output.
- CMD: shift 32 bits MSB first. SCK mode 0: mosi changes only on SCK falling edge (or at CS assertion for bit 31); miso sampled on SCK rising. After the 32nd falling edge → DATA.
- DATA: 8 SCK cycles; miso sampled MSB first on rising edges. After the 8th rising edge: rd_data=byte, rd_valid=1, rd_last=(remaining==1), SCK held low (8th falling edge completes first), → HOLD.
- HOLD: SCK stopped low, cs_n stays low. On rd_valid&&rd_ready: rd_valid=0, decrement remaining; remaining now 0 → cs_n=1, GAP; else → DATA (next SCK rise CLK_DIV cycles later).
- GAP: cs_n high for CSH_CYC cycles, then busy=0, → IDLE.
- remaining counter is LEN_W bits; no wrap. Flash address wraps per flash device; controller does not split or check.
- reset low in any state: next posedge forces reset values; in-flight transaction discarded, cs_n rises without an extra SCK edge.
- req_valid deasserted before ack: request is simply not seen; no ack.

## Timing
- Grant-to-first-SCK-rise: CLK_DIV cycles after the cycle cs_n falls.
- Bit period 2·CLK_DIV clk cycles; command phase 64·CLK_DIV cycles; each byte 16·CLK_DIV cycles plus HOLD time.
- rd_valid rises CLK_DIV cycles after the 8th rising SCK edge (on the 8th falling edge).
- With rd_ready tied high, byte-to-byte spacing is exactly 16·CLK_DIV+1 cycles.
- Back-to-back requests: next grant earliest the cycle after GAP ends; gap cs_n high ≥ CSH_CYC cycles.
- req_ack is never asserted while busy=1.

## Test plan
- req0 addr 0x012345 len 2, flash model returns 0xA5,0x3C, rd_ready=1, CLK_DIV=2 → mosi bits 0x03012345, rd_data 0xA5 then 0x3C, rd_last only on 0x3C, rd_owner=0, cs_n high ≥4 cycles after.
- Both req_valid high from reset, len 1 each → req0 acked first, then req1; next contention grants req0 again (alternation).
- rd_ready low 50 cycles on byte 1 of len 3 → spi_sck stays low, cs_n low, rd_data stable; resumes after handshake, 3 bytes total, no drop.
- req1 len 0 → req_ack[1] pulse, no cs_n assertion, no rd_valid, busy high exactly CSH_CYC+1 cycles.
- reset low mid-CMD (bit 20) → next posedge cs_n=1, sck=0, rd_valid=0; after release, new req0 completes correctly.
- CLK_DIV=1 read of 4 bytes → SCK period 2 cycles, data correct, byte spacing 17 cycles with rd_ready=1.
